// File: rtl/ponylink_test_pkg.sv
// Shared definitions for the PonyLink test-pattern generator and checker.
// Holds the checker state encoding and the default pattern constants.
package ponylink_test_pkg;

    typedef enum logic {
        UNSYNC = 1'b0,
        LOCKED = 1'b1
    } chk_state_e;

    localparam int DEF_STEP_UP   = 2;
    localparam int DEF_STEP_DOWN = 5;
    localparam int DEF_LO_THRESH = 'h4000;
    localparam int DEF_HI_THRESH = 'hc000;
    localparam int RUN_W         = 8;

endpackage

// File: rtl/ponylink_sat_counter.sv
// Event counter with synchronous clear.
// Either wraps at all-ones or holds there when SATURATE is set.
module ponylink_sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !(SATURATE && at_max)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ponylink_stream_checker.sv
// Receive-side checker for the PonyLink counting test pattern.
// Locks onto +STEP_UP / -STEP_DOWN deltas, counts errors and beats.
module ponylink_stream_checker
    import ponylink_test_pkg::*;
#(
    parameter int TDATA_WIDTH = 16,
    parameter int STEP_UP     = DEF_STEP_UP,
    parameter int STEP_DOWN   = DEF_STEP_DOWN,
    parameter int LO_THRESH   = DEF_LO_THRESH,
    parameter int HI_THRESH   = DEF_HI_THRESH,
    parameter int LOCK_BEATS  = 3,
    parameter int RESYNC_ERRS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [TDATA_WIDTH-1:0] in_tdata,
    input  logic                   in_tvalid,
    input  logic                   in_tlast,
    output logic                   in_tready,
    input  logic                   stall,
    input  logic                   clear,
    output logic                   locked,
    output logic                   recv_mode,
    output logic                   err_pulse,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic [CNT_WIDTH-1:0]   word_count,
    output logic [CNT_WIDTH-1:0]   frame_count
);

    localparam logic [TDATA_WIDTH-1:0] UP_D  = TDATA_WIDTH'(STEP_UP);
    localparam logic [TDATA_WIDTH-1:0] DN_D  = TDATA_WIDTH'(0) - TDATA_WIDTH'(STEP_DOWN);
    localparam logic [TDATA_WIDTH-1:0] LO_T  = TDATA_WIDTH'(LO_THRESH);
    localparam logic [TDATA_WIDTH-1:0] HI_T  = TDATA_WIDTH'(HI_THRESH);
    localparam logic [RUN_W-1:0]       LOCK_LAST  = RUN_W'(LOCK_BEATS - 1);
    localparam logic [RUN_W-1:0]       RESYNC_LAST = RUN_W'(RESYNC_ERRS - 1);

    chk_state_e             state_q;
    logic [TDATA_WIDTH-1:0] prev_q;
    logic                   have_prev_q;
    logic [RUN_W-1:0]       good_run_q;
    logic [RUN_W-1:0]       bad_run_q;
    logic                   recv_mode_q;
    logic                   err_pulse_q;

    logic                   accept;
    logic                   take;
    logic                   check;
    logic [TDATA_WIDTH-1:0] delta;
    logic                   good;
    logic                   err_inc;

    assign in_tready = !stall;
    assign accept    = in_tvalid && !stall;
    // clear wins over a coincident beat: the beat is dropped entirely
    assign take      = accept && !clear;
    assign check     = take && have_prev_q;
    assign delta     = in_tdata - prev_q;
    assign good      = (delta == UP_D) || (delta == DN_D);
    assign err_inc   = check && (state_q == LOCKED) && !good;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= UNSYNC;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            recv_mode_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else if (clear) begin
            state_q     <= UNSYNC;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            recv_mode_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_inc;
            if (take) begin
                prev_q      <= in_tdata;
                have_prev_q <= 1'b1;
                if (in_tdata < LO_T) begin
                    recv_mode_q <= 1'b0;
                end else if (in_tdata >= HI_T) begin
                    recv_mode_q <= 1'b1;
                end
            end
            if (check) begin
                unique case (state_q)
                    UNSYNC: begin
                        if (!good) begin
                            good_run_q <= '0;
                        end else if (good_run_q == LOCK_LAST) begin
                            state_q    <= LOCKED;
                            good_run_q <= '0;
                            bad_run_q  <= '0;
                        end else begin
                            good_run_q <= good_run_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            bad_run_q <= '0;
                        end else if (bad_run_q == RESYNC_LAST) begin
                            // next beat is a fresh seed, not checked
                            state_q     <= UNSYNC;
                            good_run_q  <= '0;
                            bad_run_q   <= '0;
                            have_prev_q <= 1'b0;
                        end else begin
                            bad_run_q <= bad_run_q + 1'b1;
                        end
                    end
                    default: state_q <= UNSYNC;
                endcase
            end
        end
    end

    ponylink_sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b1)) u_err_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

    ponylink_sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_word_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .inc_i   (take),
        .count_o (word_count)
    );

    ponylink_sat_counter #(.WIDTH(CNT_WIDTH), .SATURATE(1'b0)) u_frame_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .inc_i   (take && in_tlast),
        .count_o (frame_count)
    );

    assign locked    = (state_q == LOCKED);
    assign recv_mode = recv_mode_q;
    assign err_pulse = err_pulse_q;

endmodule
